ddr_ex_prbs_gen_chk: RTL and testbench
======================================

// Module: ddr_ex_prbs_gen_chk
// PURPOSE
// Parametrised LFSR pattern generator plus self-synchronising checker for the DDR
// example traffic driver. Generator emits one WIDTH-bit Galois-LFSR word per accepted
// beat over a valid/ready interface. Checker locks onto read-back data and counts
// mismatches. Read-back data is then verified without the checker needing the write seed.
// PARAMETERS
// WIDTH     8      LFSR / data width, 8..64
// TAPS      8'h1C  WIDTH-bit feedback mask; bit i (i>=1) XORs msb into bit i; bit 0 always = msb
// SEED      32     reset/disable value of generator LFSR (low WIDTH bits used)
// LOCK_CNT  4      consecutive matching beats needed to declare lock, 1..255
// LOSS_CNT  3      consecutive mismatching beats in LOCKED that force re-seek, 1..255
// CNT_W     16     width of error counter
// PORTS
// clk            in   1      clock, all logic rising-edge
// reset          in   1      asynchronous active-high reset
// enable         in   1      0: generator reloads SEED, checker returns to IDLE
// pause          in   1      1: generator holds, gen_valid masked
// load           in   1      generator LFSR <= ldata (priority over advance)
// ldata          in   WIDTH  load value
// gen_ready      in   1      downstream accepts gen_data
// gen_valid      out  1      gen_data valid
// gen_data       out  WIDTH  current generator LFSR value
// chk_valid      in   1      chk_data valid this cycle
// chk_data       in   WIDTH  received (read-back) word
// clr_err        in   1      clear err_flag, err_count, first-error capture
// chk_state      out  2      0 IDLE, 1 SEEK, 2 LOCKED
// chk_locked     out  1      chk_state==LOCKED
// err_flag       out  1      sticky: a mismatch occurred while LOCKED
// err_count      out  CNT_W  mismatching LOCKED beats, saturates at all-ones
// first_err_exp  out  WIDTH  expected word of first error since clear
// first_err_got  out  WIDTH  received word of first error since clear
// BEHAVIOUR
// - Reset: gen LFSR=SEED, gen_valid=0, chk_state=IDLE, chk LFSR=0, match/miss counters=0,
//   err_flag=0, err_count=0, first_err_*=0. Reset mid-operation aborts everything at once.
// - next(x): y[0]=x[W-1]; y[i]=x[i-1]^(TAPS[i]&x[W-1]) for i=1..W-1.
// - Generator: en_q <= enable (registered); gen_valid = en_q & !pause (pause is combinational).
//   enable=0: LFSR<=SEED synchronously. Else load=1: LFSR<=ldata, no advance, no beat lost
//   count. Else gen_valid&gen_ready: LFSR<=next(LFSR). Otherwise hold. Data stable while
//   valid&!ready.
// - Checker FSM, advances only on cycles with chk_valid=1; enable=0 forces IDLE, counters=0.
//   IDLE: enable=1 -> SEEK next cycle.
//   SEEK: match = (chk_data==chk LFSR); chk LFSR<=next(chk_data) every beat (reseed);
//     match -> match_cnt++, else match_cnt=0; match_cnt reaching LOCK_CNT -> LOCKED,
//     miss_cnt=0. First beat after IDLE never matches (chk LFSR=0 unless data=0).
//   LOCKED: chk LFSR<=next(chk LFSR) (free-run, no reseed); mismatch -> err_count++
//     (saturating), err_flag=1, miss_cnt++; match -> miss_cnt=0. If err_flag was 0,
//     capture first_err_exp=chk LFSR, first_err_got=chk_data. miss_cnt reaching LOSS_CNT
//     -> SEEK, match_cnt=0.
//   Mismatches in SEEK/IDLE never count as errors.
// - clr_err same cycle as LOCKED mismatch: clear applied first, so err_count=1, err_flag=1,
//   new first error captured.
// - All outputs registered except gen_valid, gen_data, chk_locked.
// - Width rules: all LFSR arithmetic is XOR on WIDTH bits; no carries. Counters are
//   8-bit internally.
// TESTING
// - WIDTH=8, SEED=32, enable=1, gen_ready=1 -> gen_data 0x20,0x40,0x80,0x1D,0x3A on
//   consecutive beats.
// - Same as above, gen_ready low 3 cycles at 0x80 -> gen_data holds 0x80, next accepted
//   word 0x1D; pause=1 -> gen_valid=0 same cycle.
// - load=1 ldata=0xA5 while gen_ready=1 -> next gen_data=0xA5, no advance that cycle;
//   enable=0 -> 0x20 next cycle.
// - Loop gen to chk from 0x20 -> chk_state SEEK then LOCKED after 1+LOCK_CNT beats;
//   err_count=0 for 1000 beats.
// - When LOCKED, flip bit0 of one beat expected 0x1D (got 0x1C) -> err_count=1, err_flag=1,
//   first_err_exp=0x1D, first_err_got=0x1C, stays LOCKED.
// - Corrupt 3 consecutive beats -> err_count=3, back to SEEK, relock after LOCK_CNT matches;
//   clr_err -> zeros.
// - Assert reset mid-stream -> all outputs at reset values immediately.

Source files
------------

// File: rtl/ddr_ex_prbs_gen_chk.sv
// ddr_ex_prbs_gen_chk
// Galois-LFSR pattern generator and self-synchronising pattern checker for the
// DDR example traffic driver. The generator produces one WIDTH-bit word for each
// accepted beat. The checker reseeds itself from the received data until it locks.
// After lock it free-runs and counts mismatching beats. Because of this, read-back
// data can be verified without knowing the write seed.
//
// Ports
//   clk, reset         rising-edge clock, async active-high reset
//   enable             0: generator reloads SEED, checker held in IDLE
//   pause              masks gen_valid and holds the generator
//   load, ldata        overwrite generator LFSR (wins over advance)
//   gen_ready/valid    generator handshake; gen_data = generator LFSR
//   chk_valid/data     received word stream
//   clr_err            clear err_flag, err_count, first-error capture
//   chk_state          0 IDLE, 1 SEEK, 2 LOCKED; chk_locked = LOCKED
//   err_flag/count     sticky error flag, saturating LOCKED-mismatch count
//   first_err_exp/got  expected/received word of first error since clear
module ddr_ex_prbs_gen_chk #(
  parameter int              WIDTH    = 8,
  parameter logic [WIDTH-1:0] TAPS    = WIDTH'(8'h1C),
  parameter logic [63:0]     SEED     = 64'd32,
  parameter int              LOCK_CNT = 4,
  parameter int              LOSS_CNT = 3,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             pause,
  input  logic             load,
  input  logic [WIDTH-1:0] ldata,
  input  logic             gen_ready,
  output logic             gen_valid,
  output logic [WIDTH-1:0] gen_data,
  input  logic             chk_valid,
  input  logic [WIDTH-1:0] chk_data,
  input  logic             clr_err,
  output logic [1:0]       chk_state,
  output logic             chk_locked,
  output logic             err_flag,
  output logic [CNT_W-1:0] err_count,
  output logic [WIDTH-1:0] first_err_exp,
  output logic [WIDTH-1:0] first_err_got
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEEK   = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] LP_SEED = SEED[WIDTH-1:0];
  localparam logic [7:0]       LP_LOCK = 8'(LOCK_CNT);
  localparam logic [7:0]       LP_LOSS = 8'(LOSS_CNT);

  // Galois step: shift left, and fold the msb back into bit 0 and every tap bit.
  function automatic logic [WIDTH-1:0] f_next(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] mask;
    mask    = {TAPS[WIDTH-1:1], 1'b1};
    f_next  = {x[WIDTH-2:0], 1'b0} ^ ({WIDTH{x[WIDTH-1]}} & mask);
  endfunction

  // ---------------------------------------------------------------- generator
  logic             r_en_q;
  logic [WIDTH-1:0] r_gen_lfsr;
  logic             w_gen_valid;

  assign w_gen_valid = r_en_q & ~pause;
  assign gen_valid   = w_gen_valid;
  assign gen_data    = r_gen_lfsr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en_q     <= 1'b0;
      r_gen_lfsr <= LP_SEED;
    end else begin
      r_en_q <= enable;
      if (!enable)                       r_gen_lfsr <= LP_SEED;
      else if (load)                     r_gen_lfsr <= ldata;
      else if (w_gen_valid && gen_ready) r_gen_lfsr <= f_next(r_gen_lfsr);
    end
  end

  // ------------------------------------------------------------------ checker
  state_t           r_state;
  logic [WIDTH-1:0] r_chk_lfsr;
  logic [7:0]       r_match_cnt;
  logic [7:0]       r_miss_cnt;
  logic             r_err_flag;
  logic [CNT_W-1:0] r_err_count;
  logic [WIDTH-1:0] r_first_exp;
  logic [WIDTH-1:0] r_first_got;

  logic             w_match;
  logic [7:0]       w_match_inc;
  logic [7:0]       w_miss_inc;
  logic [CNT_W-1:0] w_err_base;
  logic [CNT_W-1:0] w_err_inc;
  logic             w_flag_eff;

  assign w_match     = (chk_data == r_chk_lfsr);
  assign w_match_inc = r_match_cnt + 8'd1;
  assign w_miss_inc  = r_miss_cnt + 8'd1;
  // A clear in the same cycle as an error is applied first, so the new error
  // counts from zero and becomes the captured first error.
  assign w_err_base  = clr_err ? '0 : r_err_count;
  assign w_err_inc   = (&w_err_base) ? w_err_base : w_err_base + 1'b1;
  assign w_flag_eff  = r_err_flag & ~clr_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_chk_lfsr  <= '0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      r_err_flag  <= 1'b0;
      r_err_count <= '0;
      r_first_exp <= '0;
      r_first_got <= '0;
    end else begin
      if (clr_err) begin
        r_err_flag  <= 1'b0;
        r_err_count <= '0;
        r_first_exp <= '0;
        r_first_got <= '0;
      end

      if (!enable) begin
        r_state     <= S_IDLE;
        r_chk_lfsr  <= '0;
        r_match_cnt <= '0;
        r_miss_cnt  <= '0;
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_SEEK;

          // Reseed from the received word each beat; a run of LOCK_CNT
          // correct predictions means we are aligned to the stream.
          S_SEEK: if (chk_valid) begin
            r_chk_lfsr <= f_next(chk_data);
            if (w_match) begin
              if (w_match_inc == LP_LOCK) begin
                r_state     <= S_LOCKED;
                r_match_cnt <= '0;
                r_miss_cnt  <= '0;
              end else begin
                r_match_cnt <= w_match_inc;
              end
            end else begin
              r_match_cnt <= '0;
            end
          end

          // Free-run so that corrupted data cannot drag the prediction along.
          S_LOCKED: if (chk_valid) begin
            r_chk_lfsr <= f_next(r_chk_lfsr);
            if (!w_match) begin
              r_err_flag  <= 1'b1;
              r_err_count <= w_err_inc;
              if (!w_flag_eff) begin
                r_first_exp <= r_chk_lfsr;
                r_first_got <= chk_data;
              end
              if (w_miss_inc == LP_LOSS) begin
                r_state     <= S_SEEK;
                r_match_cnt <= '0;
                r_miss_cnt  <= '0;
              end else begin
                r_miss_cnt <= w_miss_inc;
              end
            end else begin
              r_miss_cnt <= '0;
            end
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign chk_state     = r_state;
  assign chk_locked    = (r_state == S_LOCKED);
  assign err_flag      = r_err_flag;
  assign err_count     = r_err_count;
  assign first_err_exp = r_first_exp;
  assign first_err_got = r_first_got;

endmodule

// File: tb/tb_ddr_ex_prbs_gen_chk.sv
// Directed bench for ddr_ex_prbs_gen_chk (WIDTH=8, TAPS=0x1C, SEED=32).
// The generator is looped back into the checker; corrupt XORs the looped data.
module tb_ddr_ex_prbs_gen_chk;
  logic        clk = 1'b0;
  logic        reset, enable, pause, load, gen_ready, clr_err;
  logic [7:0]  ldata;
  logic        gen_valid;
  logic [7:0]  gen_data;
  logic        chk_valid;
  logic [7:0]  chk_data;
  logic [1:0]  chk_state;
  logic        chk_locked, err_flag;
  logic [15:0] err_count;
  logic [7:0]  first_err_exp, first_err_got;
  logic [7:0]  corrupt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign chk_valid = gen_valid & gen_ready;
  assign chk_data  = gen_data ^ corrupt;

  ddr_ex_prbs_gen_chk #(
    .WIDTH(8), .TAPS(8'h1C), .SEED(64'd32),
    .LOCK_CNT(4), .LOSS_CNT(3), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .pause(pause), .load(load),
    .ldata(ldata), .gen_ready(gen_ready), .gen_valid(gen_valid),
    .gen_data(gen_data), .chk_valid(chk_valid), .chk_data(chk_data),
    .clr_err(clr_err), .chk_state(chk_state), .chk_locked(chk_locked),
    .err_flag(err_flag), .err_count(err_count),
    .first_err_exp(first_err_exp), .first_err_got(first_err_got)
  );

  task automatic restart();
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_word(input logic [7:0] v);
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (gen_valid && gen_data == v) ok = 1'b1;
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_word: gen_data=%h never reached required %h", gen_data, v);
    end
  endtask

  task automatic test_reset();
    n_chk++; if (gen_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", gen_valid); end
    n_chk++; if (gen_data !== 8'h20) begin n_fail++; $display("FAIL rst_data got %h want 20", gen_data); end
    n_chk++; if (chk_state !== 2'd0) begin n_fail++; $display("FAIL rst_state got %0d want 0", chk_state); end
    n_chk++; if (chk_locked !== 1'b0) begin n_fail++; $display("FAIL rst_locked got %b want 0", chk_locked); end
    n_chk++; if (err_flag !== 1'b0) begin n_fail++; $display("FAIL rst_flag got %b want 0", err_flag); end
    n_chk++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL rst_count got %0d want 0", err_count); end
    n_chk++; if (first_err_exp !== 8'h00 || first_err_got !== 8'h00) begin
      n_fail++; $display("FAIL rst_first got %h/%h want 00/00", first_err_exp, first_err_got); end
  endtask

  task automatic test_gen_seq();
    logic [7:0] exp [5] = '{8'h20, 8'h40, 8'h80, 8'h1D, 8'h3A};
    restart();
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (gen_valid !== 1'b1 || gen_data !== exp[i]) begin
        n_fail++; $display("FAIL gen_seq[%0d] got v=%b %h want v=1 %h", i, gen_valid, gen_data, exp[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall_pause();
    restart();
    @(negedge clk);
    @(negedge clk);
    n_chk++; if (gen_data !== 8'h80) begin n_fail++; $display("FAIL stall_pre got %h want 80", gen_data); end
    gen_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++;
      if (gen_valid !== 1'b1 || gen_data !== 8'h80) begin
        n_fail++; $display("FAIL stall_hold[%0d] got v=%b %h want v=1 80", i, gen_valid, gen_data);
      end
    end
    gen_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (gen_data !== 8'h1D) begin n_fail++; $display("FAIL stall_next got %h want 1d", gen_data); end
    pause = 1'b1;
    #1;
    n_chk++; if (gen_valid !== 1'b0) begin n_fail++; $display("FAIL pause_valid got %b want 0", gen_valid); end
    @(negedge clk);
    n_chk++; if (gen_data !== 8'h1D) begin n_fail++; $display("FAIL pause_hold got %h want 1d", gen_data); end
    pause = 1'b0;
    #1;
    n_chk++; if (gen_valid !== 1'b1) begin n_fail++; $display("FAIL unpause_valid got %b want 1", gen_valid); end
    @(negedge clk);
    n_chk++; if (gen_data !== 8'h3A) begin n_fail++; $display("FAIL unpause_next got %h want 3a", gen_data); end
  endtask

  task automatic test_load_disable();
    restart();
    load = 1'b1; ldata = 8'hA5;
    @(negedge clk);
    load = 1'b0;
    n_chk++; if (gen_data !== 8'hA5) begin n_fail++; $display("FAIL load got %h want a5", gen_data); end
    @(negedge clk);
    n_chk++; if (gen_data !== 8'h57) begin n_fail++; $display("FAIL load_next got %h want 57", gen_data); end
    enable = 1'b0;
    @(negedge clk);
    n_chk++; if (gen_data !== 8'h20 || gen_valid !== 1'b0) begin
      n_fail++; $display("FAIL disable got v=%b %h want v=0 20", gen_valid, gen_data); end
  endtask

  task automatic test_lock();
    restart();
    n_chk++; if (chk_state !== 2'd1) begin n_fail++; $display("FAIL seek_entry got %0d want 1", chk_state); end
    repeat (4) @(negedge clk);
    n_chk++; if (chk_state !== 2'd1) begin n_fail++; $display("FAIL pre_lock got %0d want 1", chk_state); end
    @(negedge clk);
    n_chk++; if (chk_state !== 2'd2 || chk_locked !== 1'b1) begin
      n_fail++; $display("FAIL lock got st=%0d l=%b want st=2 l=1", chk_state, chk_locked); end
    repeat (1000) @(negedge clk);
    n_chk++; if (err_count !== 16'd0 || err_flag !== 1'b0 || chk_locked !== 1'b1) begin
      n_fail++; $display("FAIL run1000 got cnt=%0d f=%b l=%b want 0 0 1", err_count, err_flag, chk_locked); end
  endtask

  task automatic test_single_err();
    wait_word(8'h1D);
    corrupt = 8'h01;
    @(negedge clk);
    corrupt = 8'h00;
    n_chk++; if (err_count !== 16'd1 || err_flag !== 1'b1) begin
      n_fail++; $display("FAIL single_cnt got cnt=%0d f=%b want 1 1", err_count, err_flag); end
    n_chk++; if (first_err_exp !== 8'h1D || first_err_got !== 8'h1C) begin
      n_fail++; $display("FAIL single_first got %h/%h want 1d/1c", first_err_exp, first_err_got); end
    n_chk++; if (chk_state !== 2'd2) begin n_fail++; $display("FAIL single_state got %0d want 2", chk_state); end
  endtask

  task automatic test_loss_relock();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    n_chk++; if (err_count !== 16'd0 || err_flag !== 1'b0 || first_err_exp !== 8'h00 || first_err_got !== 8'h00) begin
      n_fail++; $display("FAIL clr1 got cnt=%0d f=%b %h/%h want zeros", err_count, err_flag, first_err_exp, first_err_got); end
    wait_word(8'h1D);
    corrupt = 8'h01;
    repeat (3) @(negedge clk);
    corrupt = 8'h00;
    n_chk++; if (err_count !== 16'd3 || chk_state !== 2'd1) begin
      n_fail++; $display("FAIL loss got cnt=%0d st=%0d want 3 1", err_count, chk_state); end
    n_chk++; if (first_err_exp !== 8'h1D || first_err_got !== 8'h1C) begin
      n_fail++; $display("FAIL loss_first got %h/%h want 1d/1c", first_err_exp, first_err_got); end
    repeat (3) @(negedge clk);
    n_chk++; if (chk_state !== 2'd1) begin n_fail++; $display("FAIL relock_early got %0d want 1", chk_state); end
    @(negedge clk);
    n_chk++; if (chk_state !== 2'd2) begin n_fail++; $display("FAIL relock got %0d want 2", chk_state); end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    n_chk++; if (err_count !== 16'd0 || err_flag !== 1'b0 || first_err_exp !== 8'h00 || first_err_got !== 8'h00) begin
      n_fail++; $display("FAIL clr2 got cnt=%0d f=%b %h/%h want zeros", err_count, err_flag, first_err_exp, first_err_got); end
  endtask

  task automatic test_clr_same_cycle();
    corrupt = 8'h80;
    @(negedge clk);
    corrupt = 8'h00;
    n_chk++; if (err_count !== 16'd1) begin n_fail++; $display("FAIL pre_clr got %0d want 1", err_count); end
    wait_word(8'h1D);
    corrupt = 8'h01; clr_err = 1'b1;
    @(negedge clk);
    corrupt = 8'h00; clr_err = 1'b0;
    n_chk++; if (err_count !== 16'd1 || err_flag !== 1'b1) begin
      n_fail++; $display("FAIL clr_same got cnt=%0d f=%b want 1 1", err_count, err_flag); end
    n_chk++; if (first_err_exp !== 8'h1D || first_err_got !== 8'h1C) begin
      n_fail++; $display("FAIL clr_same_first got %h/%h want 1d/1c", first_err_exp, first_err_got); end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    #1;
    test_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; pause = 1'b0; load = 1'b0; ldata = 8'h00;
    gen_ready = 1'b1; clr_err = 1'b0; corrupt = 8'h00;
    repeat (2) @(negedge clk);
    test_reset();
    reset = 1'b0;
    @(negedge clk);
    test_gen_seq();
    test_stall_pause();
    test_load_disable();
    test_lock();
    test_single_err();
    test_loss_relock();
    test_clr_same_cycle();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
